// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit: architectural HI/LO, fixed-latency busy counter, F/D stall request.
// Optional madd/maddu/msub/msubu (op codes 7-10) are built in when MDU_MADD_EN is defined.
module e_muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic        md_rd_sel,
    output logic        md_busy,
    output logic        md_stall_req,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    // ---------------- operation decode ----------------
    logic       op_timed, op_div, op_div_zero;
    logic [3:0] op_cycles;

    always_comb begin
        op_timed  = 1'b0;
        op_div    = 1'b0;
        op_cycles = MULT_N;
        case (md_op)
            OP_MULT, OP_MULTU: op_timed = 1'b1;
            OP_DIV, OP_DIVU: begin
                op_timed  = 1'b1;
                op_div    = 1'b1;
                op_cycles = DIV_N;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_timed = 1'b1;
`endif
            default: ;
        endcase
    end

    assign op_div_zero = op_div && (E_rt == 32'd0);

    // ---------------- arithmetic ----------------
    logic [63:0] prod_s, prod_u;

    assign prod_s = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
    assign prod_u = {32'd0, E_rs} * {32'd0, E_rt};

    // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
    logic [31:0] a_mag, b_mag, b_mag_safe, quo_mag, rem_mag, quo_s, rem_s;
    logic [31:0] b_u_safe, quo_u, rem_u;

    assign a_mag      = E_rs[31] ? (~E_rs + 32'd1) : E_rs;
    assign b_mag      = E_rt[31] ? (~E_rt + 32'd1) : E_rt;
    assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign quo_mag    = a_mag / b_mag_safe;
    assign rem_mag    = a_mag % b_mag_safe;
    assign quo_s      = (E_rs[31] ^ E_rt[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s      = E_rs[31] ? (~rem_mag + 32'd1) : rem_mag;

    assign b_u_safe   = (E_rt == 32'd0) ? 32'd1 : E_rt;
    assign quo_u      = E_rs / b_u_safe;
    assign rem_u      = E_rs % b_u_safe;

    logic [63:0] result;

    always_comb begin
        result = 64'd0;
        case (md_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
            OP_MSUB:  result = {hi_q, lo_q} - prod_s;
            OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
            default:  result = 64'd0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    if (op_timed) begin
                        pend_hi_d = result[63:32];
                        pend_lo_d = result[31:0];
                        pend_we_d = !op_div_zero;
                        cnt_d     = op_cycles;
                        busy_d    = 1'b1;
                        state_d   = S_RUN;
                    end else if (md_op == OP_MTHI) begin
                        hi_d = E_rs;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = E_rs;
                    end
                end
            end
            S_RUN: begin
                // Starts arriving here are dropped; the running op owns HI/LO until commit.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: every register here is written with <= so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // ---------------- outputs ----------------
    assign md_busy      = busy_q;
    assign md_stall_req = busy_q | (md_start & op_timed);
    assign md_out       = md_rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed cases plus randomized ops against an arithmetic HI/LO model.
// Honours MDU_MADD_EN the same way as the design.
module tb_e_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] E_rs, E_rt;
    logic [3:0]  md_op;
    logic        md_start;
    logic        md_rd_sel;
    logic        md_busy;
    logic        md_stall_req;
    logic [31:0] md_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi, m_lo;

    e_muldiv_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .E_rs        (E_rs),
        .E_rt        (E_rt),
        .md_op       (md_op),
        .md_start    (md_start),
        .md_rd_sel   (md_rd_sel),
        .md_busy     (md_busy),
        .md_stall_req(md_stall_req),
        .md_out      (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        md_rd_sel = 1'b1;
        #1 check({tag, "_hi"}, md_out, hi);
        md_rd_sel = 1'b0;
        #1 check({tag, "_lo"}, md_out, lo);
    endtask

    function automatic bit is_timed(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    // Reference: HI/LO after op, from plain integer arithmetic on the committed state.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] nh, output logic [31:0] nl);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up, acc;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sp = sa * sb;
        up = ua * ub;
        acc = {m_hi, m_lo};
        nh = m_hi;
        nl = m_lo;
        case (op)
            4'd1: {nh, nl} = sp;
            4'd2: {nh, nl} = up;
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nl = 32'h8000_0000;
                    nh = 32'd0;
                end else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    nl = ia / ib;
                    nh = ia % ib;
                end
            end
            4'd4: if (b != 0) begin
                nl = a / b;
                nh = a % b;
            end
            4'd5: nh = a;
            4'd6: nl = a;
`ifdef MDU_MADD_EN
            4'd7:  {nh, nl} = acc + sp;
            4'd8:  {nh, nl} = acc + up;
            4'd9:  {nh, nl} = acc - sp;
            4'd10: {nh, nl} = acc - up;
`endif
            default: ;
        endcase
    endtask

    // Timed op: start cycle, N busy cycles with old HI/LO visible, then commit with busy low.
    task automatic run_timed(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] poke_op);
        logic [31:0] nh, nl;
        int n;
        model(op, a, b, nh, nl);
        n = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
        E_rs = a; E_rt = b; md_op = op; md_start = 1'b1;
        #1 check({tag, "_stall_start"}, md_stall_req, 1);
        check({tag, "_busy_start"}, md_busy, 0);
        @(posedge clk); #1;
        md_start = 1'b0; md_op = 4'd0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy_run"}, md_busy, 1);
            check({tag, "_stall_run"}, md_stall_req, 1);
            check_out({tag, "_old"}, m_hi, m_lo);
            if (poke_op != 4'd0 && i == 1) begin
                E_rs = $urandom; E_rt = $urandom; md_op = poke_op; md_start = 1'b1;
            end
            @(posedge clk); #1;
            md_start = 1'b0; md_op = 4'd0;
        end
        check({tag, "_busy_end"}, md_busy, 0);
        m_hi = nh;
        m_lo = nl;
        check_out({tag, "_new"}, m_hi, m_lo);
    endtask

    task automatic run_move(input string tag, input logic [3:0] op, input logic [31:0] a);
        logic [31:0] nh, nl;
        model(op, a, 32'd0, nh, nl);
        E_rs = a; E_rt = $urandom; md_op = op; md_start = 1'b1;
        #1 check({tag, "_stall"}, md_stall_req, 0);
        @(posedge clk); #1;
        md_start = 1'b0; md_op = 4'd0;
        check({tag, "_busy"}, md_busy, 0);
        m_hi = nh;
        m_lo = nl;
        check_out(tag, m_hi, m_lo);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; E_rs = '0; E_rt = '0; md_op = '0; md_start = 1'b0; md_rd_sel = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1 check("rst_busy", md_busy, 0);
        check("rst_stall", md_stall_req, 0);
        check_out("rst", 32'd0, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_timed("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 4'd0);
        check_out("mult_k", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_timed("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 4'd0);
        check_out("multu_k", 32'h0000_0002, 32'hFFFF_FFFA);
        run_timed("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0);
        check_out("div_k", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_timed("divu", 4'd4, 32'd7, 32'd2, 4'd0);
        check_out("divu_k", 32'd1, 32'd3);
        run_timed("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0);
        check_out("div_ovf_k", 32'd0, 32'h8000_0000);

        run_move("mthi", 4'd5, 32'h1234);
        run_move("mtlo", 4'd6, 32'h5678);
        run_timed("divz", 4'd4, 32'hDEAD_BEEF, 32'd0, 4'd1);
        check_out("divz_k", 32'h1234, 32'h5678);
        run_timed("poke_mtlo", 4'd2, 32'h0001_0000, 32'h0001_0000, 4'd6);

        // Reset mid-run: abandon the op, clear HI/LO, no late commit.
        E_rs = 32'h7FFF_FFFF; E_rt = 32'h7FFF_FFFF; md_op = 4'd1; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0; md_op = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("rstrun_busy", md_busy, 0);
        check_out("rstrun", 32'd0, 32'd0);
        repeat (MULT_N + 2) @(posedge clk);
        #1 check("rstrun_late_busy", md_busy, 0);
        check_out("rstrun_late", 32'd0, 32'd0);

        // Accumulate op code 8 with and without the feature.
        run_move("pre_hi", 4'd5, 32'd0);
        run_move("pre_lo", 4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_timed("maddu", 4'd8, 32'd1, 32'd1, 4'd0);
        check_out("maddu_k", 32'd1, 32'd0);
`else
        E_rs = 32'd1; E_rt = 32'd1; md_op = 4'd8; md_start = 1'b1;
        #1 check("op8_stall", md_stall_req, 0);
        @(posedge clk); #1;
        md_start = 1'b0; md_op = 4'd0;
        check("op8_busy", md_busy, 0);
        check_out("op8", 32'd0, 32'hFFFF_FFFF);
`endif

        // Randomized operations against the model.
        for (int k = 0; k < 24; k++) begin
`ifdef MDU_MADD_EN
            op = 4'($urandom_range(1, 10));
`else
            op = 4'($urandom_range(1, 6));
`endif
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (is_timed(op))
                run_timed("rnd", op, a, b, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 6)) : 4'd0);
            else
                run_move("rnd_mv", op, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
Execute-stage multiply/divide unit. It consumes the operand pair and the decoded MD operation that the D→E pipeline register presents to the E stage. It holds the architectural HI/LO registers and models the fixed multi-cycle latency of mult/div with a busy counter. It also raises a stall request that the hazard unit uses to freeze the F/D stages while an MD instruction is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
E_rs  input  32  operand A (rs value, already forwarded)
E_rt  input  32  operand B (rt value, already forwarded)
md_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu (codes 7-10 only with the macro)
md_start  input  1  qualifies md_op for one cycle; meaningful only when md_op != 0
md_rd_sel  input  1  0 = read LO, 1 = read HI
md_busy  output  1  registered; high while a timed operation is in progress
md_stall_req  output  1  combinational: md_busy | (md_start & md_op in 1..4/7..10)
md_out  output  32  combinational: LO or HI per md_rd_sel

Behaviour:
- Reset is synchronous, active-high on clk. HI=0, LO=0, counter=0, md_busy=0, internal result latches=0. md_out follows to 0.
- States: IDLE (counter==0) and RUN (counter>0).
- IDLE, md_start with a timed op: capture the result computed from E_rs/E_rt into pending HI/LO. Load counter with MULT_CYCLES or DIV_CYCLES. md_busy=1 from the next cycle.
- RUN: counter decrements each cycle. md_busy stays high for exactly N cycles (N = the loaded value). On the edge where the counter reaches 0, pending values commit to HI/LO and md_busy falls together with the commit. Start at cycle t → new HI/LO and md_busy=0 visible in cycle t+N+1.
- mthi/mtlo (md_start & op 5/6) in IDLE: write E_rs to HI or LO at the next edge; no busy cycles.
- md_start while md_busy=1: ignored entirely; the running op is unaffected. The hazard unit guarantees this does not happen, but the RTL must be safe if it does.
- md_op = 0, or an undefined code, with md_start: no effect.
- mult: signed 32×32→64 product. multu: unsigned. HI = [63:32], LO = [31:0].
- div: signed; quotient truncates toward zero, LO = quotient, HI = remainder (sign of dividend). divu: unsigned.
- Divide by zero (E_rt==0): busy timing unchanged; HI/LO are NOT modified at commit.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- md_out reflects committed HI/LO only. Pending results are never visible early.
- md_stall_req is asserted combinationally in the start cycle, so a dependent mfhi/mflo in D stalls with no gap.
- Reset while RUN: operation abandoned, HI/LO=0, md_busy=0 in the next cycle.

Optional Feature:
MDU_MADD_EN. Defined: op codes 7-10 are legal and timed with MULT_CYCLES.
- madd/maddu: {HI,LO} += signed/unsigned product.
- msub/msubu: {HI,LO} -= product.
- The accumulate uses the {HI,LO} committed at start time; mod 2^64 wrap.
Undefined: codes 7-10 are treated as no-op, and md_stall_req is not asserted for them.

Test Plan:
- Signed mult: E_rs=0xFFFFFFFE, E_rt=3, op=1 start at t → md_busy high t+1..t+5. Cycle t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult: same operands, op=2 → HI=0x00000002, LO=0xFFFFFFFA. Before t+6, md_out still shows the old values.
- Signed div: E_rs=0xFFFFFFF9 (-7), E_rt=2, op=3 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with op=4 on 7/2 → LO=3, HI=1.
- Divide by zero and ignored start: HI/LO preloaded via mthi 0x1234 / mtlo 0x5678, then divu with E_rt=0 → after 10 busy cycles HI=0x1234, LO=0x5678. A second md_start mid-run is ignored (busy still ends at t+11).
- Reset mid-run: start mult, assert reset in cycle t+3 → cycle t+4: md_busy=0, HI=LO=0, no later commit.
- Macro MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1×1 → HI=1, LO=0. Without the macro, op=8 leaves HI/LO unchanged and md_stall_req=0.
